// File: rtl/sp_pe_pipe.sv
// Pipelined sparse-row x dense-column dot-product PE: multiply stage, registered adder tree, row accumulator.
// Define SP_PE_SAT_EN to saturate the accumulator and the narrowed output instead of wrapping.
module sp_pe_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int NNZ_LANES  = 4,
   parameter int COL_DIM    = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int FRAC_BITS  = 0,
   parameter int OUT_WIDTH  = 8,
   parameter int ROW_IDX_W  = 16,
   localparam int TREE_STAGES   = (NNZ_LANES > 1) ? $clog2(NNZ_LANES) : 0,
   localparam int COL_IDX_WIDTH = (COL_DIM > 1) ? $clog2(COL_DIM) : 1,
   localparam int CNT_W         = $clog2(NNZ_LANES) + 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [NNZ_LANES-1:0][COL_IDX_WIDTH-1:0]  in_col_idx,
   input  logic [NNZ_LANES-1:0][DATA_WIDTH-1:0]     in_value,
   input  logic [CNT_W-1:0]                         in_count,
   input  logic                                     in_last,
   input  logic [COL_DIM-1:0][DATA_WIDTH-1:0]       weight_i,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [OUT_WIDTH-1:0]                     out_data,
   output logic [ROW_IDX_W-1:0]                     out_row_idx,
   output logic                                     out_sat,
   output logic                                     err_col_o
);

   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int SUM_W  = PROD_W + TREE_STAGES;

   typedef enum logic {IDLE, ACC} state_t;

   function automatic int nodes_at(input int level);
      return (NNZ_LANES + (1 << level) - 1) >> level;
   endfunction

   function automatic int clamp_idx(input int k);
      return (k < NNZ_LANES) ? k : NNZ_LANES - 1;
   endfunction

   logic                 en;
   logic [SUM_W-1:0]     node_d [TREE_STAGES+1][NNZ_LANES];
   logic [SUM_W-1:0]     node_q [TREE_STAGES+1][NNZ_LANES];
   logic [TREE_STAGES:0] vld_d, vld_q, last_d, last_q;
   logic                 err_col_d, err_col_q;

   state_t               state_d, state_q;
   logic [ACC_WIDTH-1:0] acc_d, acc_q, acc_total;
   logic                 out_valid_d, out_valid_q;
   logic [OUT_WIDTH-1:0] out_data_d, out_data_q;
   logic                 out_sat_d, out_sat_q;
   logic [ROW_IDX_W-1:0] row_idx_d, row_idx_q;
   logic [SUM_W-1:0]     sum_top;
   logic                 tree_valid, tree_last;

   assign en       = ~out_valid_q | out_ready;
   assign in_ready = en;

   // Level 0 holds the lane products; lanes at or beyond in_count contribute zero, which also clamps oversize counts.
   always_comb begin
      err_col_d = err_col_q;
      vld_d[0]  = in_valid;
      last_d[0] = in_last;
      for (int l = 1; l <= TREE_STAGES; l++) begin
         vld_d[l]  = vld_q[l-1];
         last_d[l] = last_q[l-1];
      end
      for (int i = 0; i < NNZ_LANES; i++) begin
         node_d[0][i] = '0;
         if (i < int'(in_count)) begin
            if (int'(in_col_idx[i]) < COL_DIM)
               node_d[0][i] = SUM_W'({{DATA_WIDTH{1'b0}}, in_value[i]} *
                                     {{DATA_WIDTH{1'b0}}, weight_i[in_col_idx[i]]});
            else if (in_valid && en)
               err_col_d = 1'b1;
         end
      end
      for (int l = 1; l <= TREE_STAGES; l++) begin
         for (int i = 0; i < NNZ_LANES; i++) begin
            node_d[l][i] = '0;
            if (2*i + 1 < nodes_at(l-1))
               node_d[l][i] = node_q[l-1][clamp_idx(2*i)] + node_q[l-1][clamp_idx(2*i+1)];
            else if (2*i < nodes_at(l-1))
               node_d[l][i] = node_q[l-1][clamp_idx(2*i)];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l <= TREE_STAGES; l++)
            for (int i = 0; i < NNZ_LANES; i++)
               node_q[l][i] <= '0;
         vld_q     <= '0;
         last_q    <= '0;
         err_col_q <= 1'b0;
      end else begin
         err_col_q <= err_col_d;
         if (en) begin
            node_q <= node_d;
            vld_q  <= vld_d;
            last_q <= last_d;
         end
      end
   end

   assign sum_top    = node_q[TREE_STAGES][0];
   assign tree_valid = vld_q[TREE_STAGES];
   assign tree_last  = last_q[TREE_STAGES];

   // Row accumulator FSM; a pending result is only replaced once it has been handed off (en).
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q & ~out_ready;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      row_idx_d   = row_idx_q + ROW_IDX_W'(out_valid_q & out_ready);
`ifdef SP_PE_SAT_EN
      begin
         logic [ACC_WIDTH:0]   acc_wide;
         logic [ACC_WIDTH-1:0] r;
         acc_wide  = (ACC_WIDTH+1)'((state_q == ACC) ? acc_q : '0) + (ACC_WIDTH+1)'(sum_top);
         acc_total = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];
         r         = acc_total >> FRAC_BITS;
         if (en && tree_valid && tree_last) begin
            if ((r >> OUT_WIDTH) != '0) begin
               out_data_d = '1;
               out_sat_d  = 1'b1;
            end else begin
               out_data_d = OUT_WIDTH'(r);
               out_sat_d  = 1'b0;
            end
         end
      end
`else
      acc_total = ((state_q == ACC) ? acc_q : '0) + ACC_WIDTH'(sum_top);
      if (en && tree_valid && tree_last) begin
         out_data_d = OUT_WIDTH'(acc_total >> FRAC_BITS);
         out_sat_d  = 1'b0;
      end
`endif
      if (en && tree_valid) begin
         case (state_q)
            IDLE, ACC: begin
               if (tree_last) begin
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  state_d     = IDLE;
               end else begin
                  acc_d   = acc_total;
                  state_d = ACC;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         row_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         row_idx_q   <= row_idx_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_sat     = out_sat_q;
   assign out_row_idx = row_idx_q;
   assign err_col_o   = err_col_q;

endmodule

// File: tb/tb_sp_pe_pipe.sv
// Self-checking bench for sp_pe_pipe: vector table, hand sequences for stall/reset corners, randomized rows vs a row-sum model.
// A second instance with COL_DIM=6 exercises out-of-range column indices, which a 3-bit index cannot express at COL_DIM=8.
module tb_sp_pe_pipe;

   localparam int DW  = 8;
   localparam int NL  = 4;
   localparam int CD  = 8;
   localparam int CDE = 6;
   localparam int CIW = 3;
   localparam int CW  = 3;
   localparam longint ACC_MAX = (longint'(1) << 24) - 1;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [NL-1:0][CIW-1:0]  in_col_idx = '0;
   logic [NL-1:0][DW-1:0]   in_value = '0;
   logic [CW-1:0]           in_count = '0;
   logic                    in_last = 1'b0;
   logic [CD-1:0][DW-1:0]   weight_i = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [7:0]              out_data;
   logic [15:0]             out_row_idx;
   logic                    out_sat;
   logic                    err_col_o;

   logic                    e_in_valid = 1'b0;
   logic                    e_in_ready;
   logic [NL-1:0][CIW-1:0]  e_in_col_idx = '0;
   logic [NL-1:0][DW-1:0]   e_in_value = '0;
   logic [CW-1:0]           e_in_count = '0;
   logic [CDE-1:0][DW-1:0]  e_weight = '0;
   logic                    e_out_valid;
   logic [7:0]              e_out_data;
   logic [15:0]             e_out_row_idx;
   logic                    e_out_sat;
   logic                    e_err_col;

   sp_pe_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_col_idx(in_col_idx), .in_value(in_value), .in_count(in_count), .in_last(in_last),
      .weight_i(weight_i), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row_idx(out_row_idx), .out_sat(out_sat), .err_col_o(err_col_o)
   );

   sp_pe_pipe #(.COL_DIM(CDE)) dut_e (
      .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
      .in_col_idx(e_in_col_idx), .in_value(e_in_value), .in_count(e_in_count), .in_last(1'b1),
      .weight_i(e_weight), .out_valid(e_out_valid), .out_ready(1'b1), .out_data(e_out_data),
      .out_row_idx(e_out_row_idx), .out_sat(e_out_sat), .err_col_o(e_err_col)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0]          count;
      logic [NL-1:0][CIW-1:0] cols;
      logic [NL-1:0][DW-1:0]  vals;
      int                     exp_data;
      bit                     exp_sat;
   } vec_t;

   typedef struct {
      int data;
      bit sat;
   } res_t;

   vec_t   vecs [6];
   res_t   exp_q [$];
   res_t   mon_r;
   int     errors = 0;
   int     checks = 0;
   int     emitted = 0;
   int     ready_mode = 0;
   longint row_acc = 0;

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // 0: always ready, 1: random backpressure, 2: blocked
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       out_ready = ($urandom_range(0, 3) != 0);
         2:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_output("result_expected", exp_q.size(), 1);
         end else begin
            mon_r = exp_q.pop_front();
            check_output("out_data", out_data, mon_r.data);
            check_output("out_sat", out_sat, mon_r.sat);
            check_output("out_row_idx", out_row_idx, emitted % 65536);
            emitted++;
         end
      end
   end

   // Reference: each row is the sum over its beats of value*weight[col] over valid in-range lanes.
   task automatic wait_accept(input bit use_exp, input int ed, input bit es);
      int     n = 0;
      int     c;
      longint b = 0;
      res_t   r;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_output("accept_timeout", n, 0);
      c = (int'(in_count) > NL) ? NL : int'(in_count);
      for (int i = 0; i < c; i++)
         if (int'(in_col_idx[i]) < CD)
            b += longint'(in_value[i]) * longint'(weight_i[in_col_idx[i]]);
`ifdef SP_PE_SAT_EN
      row_acc = (row_acc + b > ACC_MAX) ? ACC_MAX : row_acc + b;
`else
      row_acc = (row_acc + b) % (ACC_MAX + 1);
`endif
      if (in_last) begin
`ifdef SP_PE_SAT_EN
         r.data = (row_acc > 255) ? 255 : int'(row_acc);
         r.sat  = (row_acc > 255);
`else
         r.data = int'(row_acc % 256);
         r.sat  = 1'b0;
`endif
         if (use_exp) begin
            r.data = ed;
            r.sat  = es;
         end
         exp_q.push_back(r);
         row_acc = 0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [CW-1:0] cnt, input logic [NL-1:0][CIW-1:0] cols,
                                 input logic [NL-1:0][DW-1:0] vals, input bit last,
                                 input bit use_exp, input int ed, input bit es);
      in_count   = cnt;
      in_col_idx = cols;
      in_value   = vals;
      in_last    = last;
      in_valid   = 1'b1;
      wait_accept(use_exp, ed, es);
   endtask

   task automatic wait_drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check_output("drain_pending", exp_q.size(), 0);
   endtask

   task automatic do_reset(input int cycles);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      emitted = 0;
      row_acc = 0;
   endtask

   task automatic set_weights_index();
      for (int k = 0; k < CD; k++) weight_i[k] = 8'(k + 1);
   endtask

   task automatic e_row(input logic [CW-1:0] cnt, input logic [NL-1:0][CIW-1:0] cols,
                        input logic [NL-1:0][DW-1:0] vals, input int ed, input bit eerr, input string name);
      int n = 0;
      e_in_count   = cnt;
      e_in_col_idx = cols;
      e_in_value   = vals;
      e_in_valid   = 1'b1;
      @(posedge clk);
      #1;
      e_in_valid = 1'b0;
      while (!e_out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output({name, "_valid"}, e_out_valid, 1);
      check_output({name, "_data"}, e_out_data, ed);
      check_output({name, "_err"}, e_err_col, eerr);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int     lat;
      int     hold_idx;
      logic [NL-1:0][CIW-1:0] rc;
      logic [NL-1:0][DW-1:0]  rv;
      int     nb;

      vecs[0] = '{3'd3, {3'd0, 3'd5, 3'd2, 3'd0}, {8'd0, 8'd3, 8'd2, 8'd1}, 25, 1'b0};
      vecs[1] = '{3'd4, {3'd7, 3'd4, 3'd3, 3'd1}, {8'd2, 8'd2, 8'd2, 8'd2}, 38, 1'b0};
`ifdef SP_PE_SAT_EN
      vecs[2] = '{3'd2, {3'd0, 3'd0, 3'd7, 3'd7}, {8'd9, 8'd9, 8'd255, 8'd255}, 255, 1'b1};
`else
      vecs[2] = '{3'd2, {3'd0, 3'd0, 3'd7, 3'd7}, {8'd9, 8'd9, 8'd255, 8'd255}, 240, 1'b0};
`endif
      vecs[3] = '{3'd7, {3'd3, 3'd2, 3'd1, 3'd0}, {8'd1, 8'd1, 8'd1, 8'd1}, 10, 1'b0};
      vecs[4] = '{3'd1, {3'd0, 3'd0, 3'd0, 3'd6}, {8'd99, 8'd99, 8'd99, 8'd10}, 70, 1'b0};
      vecs[5] = '{3'd0, {3'd1, 3'd1, 3'd1, 3'd1}, {8'd50, 8'd50, 8'd50, 8'd50}, 0, 1'b0};

      for (int k = 0; k < CDE; k++) e_weight[k] = 8'(k + 1);
      set_weights_index();

      // Reset held three cycles
      do_reset(3);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_out_data", out_data, 0);
      check_output("rst_row_idx", out_row_idx, 0);
      check_output("rst_out_sat", out_sat, 0);
      check_output("rst_err_col", err_col_o, 0);
      check_output("rst_in_ready", in_ready, 1);
      check_output("rst_e_err_col", e_err_col, 0);

      // Single-beat row with latency measurement
      apply_stimulus(vecs[0].count, vecs[0].cols, vecs[0].vals, 1'b1, 1'b1, 25, 1'b0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_output("latency_edges_after_accept", lat, 3);
      wait_drain(50);

      // Table rows back-to-back
      for (int v = 0; v < 6; v++)
         apply_stimulus(vecs[v].count, vecs[v].cols, vecs[v].vals, 1'b1, 1'b1, vecs[v].exp_data, vecs[v].exp_sat);
      wait_drain(50);

      // Two-beat row overflowing the 8-bit output
      for (int k = 0; k < CD; k++) weight_i[k] = 8'd10;
      apply_stimulus(3'd4, {3'd3, 3'd2, 3'd1, 3'd0}, {4{8'd10}}, 1'b0, 1'b0, 0, 1'b0);
`ifdef SP_PE_SAT_EN
      apply_stimulus(3'd1, {3'd0, 3'd0, 3'd0, 3'd7}, {8'd0, 8'd0, 8'd0, 8'd1}, 1'b1, 1'b1, 255, 1'b1);
`else
      apply_stimulus(3'd1, {3'd0, 3'd0, 3'd0, 3'd7}, {8'd0, 8'd0, 8'd0, 8'd1}, 1'b1, 1'b1, 154, 1'b0);
`endif
      wait_drain(50);
      set_weights_index();

      // Output blocked: pipe fills, result held, pending beat waits
      ready_mode = 2;
      hold_idx = emitted % 65536;
      for (int v = 0; v < 4; v++)
         apply_stimulus(vecs[v].count, vecs[v].cols, vecs[v].vals, 1'b1, 1'b1, vecs[v].exp_data, vecs[v].exp_sat);
      in_count   = vecs[5].count;
      in_col_idx = vecs[5].cols;
      in_value   = vecs[5].vals;
      in_last    = 1'b1;
      in_valid   = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_output("stall_out_valid", out_valid, 1);
      check_output("stall_out_data", out_data, 25);
      check_output("stall_in_ready", in_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      check_output("stall_hold_data", out_data, 25);
      check_output("stall_hold_row_idx", out_row_idx, hold_idx);
      ready_mode = 0;
      wait_accept(1'b1, 0, 1'b0);
      wait_drain(50);

      // Reset in the middle of a row discards the partial sum
      apply_stimulus(3'd4, {3'd3, 3'd2, 3'd1, 3'd0}, {4{8'd7}}, 1'b0, 1'b0, 0, 1'b0);
      do_reset(2);
      check_output("midrst_out_valid", out_valid, 0);
      apply_stimulus(vecs[0].count, vecs[0].cols, vecs[0].vals, 1'b1, 1'b1, 25, 1'b0);
      wait_drain(50);

      // Out-of-range columns on the COL_DIM=6 instance
      e_row(3'd1, {3'd7, 3'd7, 3'd7, 3'd0}, {8'd9, 8'd9, 8'd9, 8'd4}, 4, 1'b0, "e_masked_lanes");
      e_row(3'd2, {3'd0, 3'd0, 3'd1, 3'd7}, {8'd0, 8'd0, 8'd3, 8'd5}, 6, 1'b1, "e_bad_col");
      e_row(3'd1, {3'd0, 3'd0, 3'd0, 3'd5}, {8'd0, 8'd0, 8'd0, 8'd2}, 12, 1'b1, "e_sticky");

      // Randomized multi-beat rows under random backpressure and input gaps
      ready_mode = 1;
      for (int r = 0; r < 40; r++) begin
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < CD; k++) weight_i[k] = 8'($urandom);
            for (int i = 0; i < NL; i++) begin
               rc[i] = 3'($urandom_range(0, 7));
               rv[i] = 8'($urandom);
            end
            apply_stimulus(3'($urandom_range(0, 5)), rc, rv, (b == nb - 1), 1'b0, 0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
      end
      ready_mode = 0;
      wait_drain(400);
      check_output("main_err_col", err_col_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
